radix5_input_gather: RTL and testbench

- Upstream neighbour of the radix-5 butterfly stage.
- Accepts a serial stream of complex samples, one per cycle, with valid/ready handshake, and groups them into frames of 5.
- Presents each frame in parallel on the a..e ports for the butterfly.
- Ping-pong banks let the next frame fill while the current one waits for out_ready.
- Sample words are opaque 32-bit values: no arithmetic is performed on them.

---
 rtl/radix5_input_gather_pkg.sv | 17 +
 rtl/radix5_frame_bank.sv | 61 ++++++
 rtl/radix5_input_gather.sv | 138 +++++++++++++
 tb/tb_radix5_input_gather.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/radix5_input_gather_pkg.sv
// Shared constants and types for the radix-5 input gather block.
// Optional feature macro used by the top: RADIX5_GATHER_ERR_EN.
package radix5_input_gather_pkg;

   localparam int RADIX5_NPT    = 5;
   localparam int RADIX5_DW     = 32;
   localparam int RADIX5_SLOT_W = 3;

   // One complex sample; the words are opaque and never combined arithmetically.
   typedef struct packed {
      logic [RADIX5_DW-1:0] re;
      logic [RADIX5_DW-1:0] img;
   } cplx_t;

   typedef logic [RADIX5_SLOT_W-1:0] slot_t;

endpackage

// File: rtl/radix5_frame_bank.sv
// One 5-slot register bank of complex samples plus its full flag.
// The top instantiates two of these as ping-pong frame buffers.
module radix5_frame_bank
   import radix5_input_gather_pkg::*;
(
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   we,
   input  logic [RADIX5_SLOT_W-1:0]               slot,
   input  logic [RADIX5_DW-1:0]                   wr_re,
   input  logic [RADIX5_DW-1:0]                   wr_img,
   input  logic                                   set_full,
   input  logic                                   clr_full,
   output logic                                   full,
   output logic [RADIX5_NPT-1:0][RADIX5_DW-1:0]   rd_re,
   output logic [RADIX5_NPT-1:0][RADIX5_DW-1:0]   rd_img
);

   cplx_t [RADIX5_NPT-1:0] slots_q, slots_d;
   logic                   full_q, full_d;

   // Next-state: write the addressed slot, then update the full flag.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
      slots_d = slots_q;
      full_d  = full_q;
      for (int i = 0; i < RADIX5_NPT; i++) begin
         if (we && slot == slot_t'(i)) begin
            slots_d[i].re  = wr_re;
            slots_d[i].img = wr_img;
         end
      end
      // Set and clear never target the same bank in one cycle; set wins if they ever did.
      if (clr_full) full_d = 1'b0;
      if (set_full) full_d = 1'b1;
   end

   // Bank registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
      if (rst) begin
         // NOTE: the sample words are reset too, because the a..e outputs must read zero after reset.
         slots_q <= '0;
         full_q  <= 1'b0;
      end else begin
         slots_q <= slots_d;
         full_q  <= full_d;
      end
   end

   // Expose the stored slots as flat per-slot words.
   always_comb begin
      for (int i = 0; i < RADIX5_NPT; i++) begin
         rd_re[i]  = slots_q[i].re;
         rd_img[i] = slots_q[i].img;
      end
   end

   assign full = full_q;

endmodule

// File: rtl/radix5_input_gather.sv
// Radix-5 input gather: collects a serial complex stream into 5-sample
// frames in two ping-pong banks and presents each frame in parallel.
// Optional sticky framing-error output enabled by RADIX5_GATHER_ERR_EN.
module radix5_input_gather
   import radix5_input_gather_pkg::*;
#(
   parameter int DW  = RADIX5_DW,
   parameter int NPT = RADIX5_NPT
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_sof,
   input  logic [DW-1:0] in_re,
   input  logic [DW-1:0] in_img,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] a_re,
   output logic [DW-1:0] a_img,
   output logic [DW-1:0] b_re,
   output logic [DW-1:0] b_img,
   output logic [DW-1:0] c_re,
   output logic [DW-1:0] c_img,
   output logic [DW-1:0] d_re,
   output logic [DW-1:0] d_img,
   output logic [DW-1:0] e_re,
   output logic [DW-1:0] e_img
`ifdef RADIX5_GATHER_ERR_EN
   ,
   output logic          frame_err
`endif
);

   localparam slot_t LAST_SLOT = slot_t'(NPT - 1);

   slot_t                  wcnt_q, wcnt_d;
   logic                   wb_q, wb_d;
   logic                   rb_q, rb_d;
   logic [1:0]             full;
   logic                   accept;
   logic                   drain;
   slot_t                  slot;
   logic [1:0]             we, set_full, clr_full;
   logic [NPT-1:0][DW-1:0] rd_re  [2];
   logic [NPT-1:0][DW-1:0] rd_img [2];

   // Ready depends on registered state only, so a drain frees space one cycle later.
   assign in_ready  = !full[wb_q];
   assign out_valid = full[rb_q];

   // Write-side and read-side control: slot selection, bank flips, full set/clear.
   always_comb begin
      accept   = in_valid && in_ready;
      drain    = out_valid && out_ready;
      slot     = in_sof ? '0 : wcnt_q;
      wcnt_d   = wcnt_q;
      wb_d     = wb_q;
      rb_d     = rb_q;
      we       = '0;
      set_full = '0;
      clr_full = '0;
      if (accept) begin
         we[wb_q] = 1'b1;
         if (slot == LAST_SLOT) begin
            set_full[wb_q] = 1'b1;
            wb_d           = !wb_q;
            wcnt_d         = '0;
         end else begin
            wcnt_d = slot + 1'b1;
         end
      end
      // A drain always hits the read bank, which cannot be the bank being written.
      if (drain) begin
         clr_full[rb_q] = 1'b1;
         rb_d           = !rb_q;
      end
   end

   // Control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt_q <= '0;
         wb_q   <= 1'b0;
         rb_q   <= 1'b0;
      end else begin
         wcnt_q <= wcnt_d;
         wb_q   <= wb_d;
         rb_q   <= rb_d;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_bank
      radix5_frame_bank u_bank (
         .clk      (clk),
         .rst      (rst),
         .we       (we[g]),
         .slot     (slot),
         .wr_re    (in_re),
         .wr_img   (in_img),
         .set_full (set_full[g]),
         .clr_full (clr_full[g]),
         .full     (full[g]),
         .rd_re    (rd_re[g]),
         .rd_img   (rd_img[g])
      );
   end

   // Outputs come straight from the read bank; they hold after a drain and are stale while out_valid is low.
   assign a_re  = rd_re[rb_q][0];
   assign a_img = rd_img[rb_q][0];
   assign b_re  = rd_re[rb_q][1];
   assign b_img = rd_img[rb_q][1];
   assign c_re  = rd_re[rb_q][2];
   assign c_img = rd_img[rb_q][2];
   assign d_re  = rd_re[rb_q][3];
   assign d_img = rd_img[rb_q][3];
   assign e_re  = rd_re[rb_q][4];
   assign e_img = rd_img[rb_q][4];

`ifdef RADIX5_GATHER_ERR_EN
   logic err_q, err_d;

   // Error when sof disagrees with the slot counter: sof mid-frame, or a frame starting without sof.
   always_comb begin
      err_d = err_q | (accept && (in_sof == (wcnt_q != '0)));
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign frame_err = err_q;
`endif

endmodule

// File: tb/tb_radix5_input_gather.sv
// Scoreboard bench for radix5_input_gather: the driver pushes expected
// frames, a negedge monitor pops and compares them and checks hold-while-stalled.
module tb_radix5_input_gather;

   typedef logic [9:0][31:0] frame_t;  // [0..4] re of slots a..e, [5..9] img

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_sof = 1'b0;
   logic [31:0] in_re = '0;
   logic [31:0] in_img = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] a_re, a_img, b_re, b_img, c_re, c_img, d_re, d_img, e_re, e_img;
`ifdef RADIX5_GATHER_ERR_EN
   logic        frame_err;
`endif

   int     n_cmp = 0;
   int     n_err = 0;
   int     cyc = 0;
   int     stalls = 0;
   int     n_pop = 0;
   int     last_acc_cyc = 0;
   bit     rand_on = 1'b0;
   bit     prev_stall = 1'b0;
   frame_t prev_fr;
   frame_t exp_q [$];
   int     pop_cyc [$];

   radix5_input_gather dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sof    (in_sof),
      .in_re     (in_re),
      .in_img    (in_img),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a_re      (a_re),
      .a_img     (a_img),
      .b_re      (b_re),
      .b_img     (b_img),
      .c_re      (c_re),
      .c_img     (c_img),
      .d_re      (d_re),
      .d_img     (d_img),
      .e_re      (e_re),
      .e_img     (e_img)
`ifdef RADIX5_GATHER_ERR_EN
      ,
      .frame_err (frame_err)
`endif
   );

   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic frame_t seq_frame(input logic [31:0] re0, input logic [31:0] img0);
      frame_t f;
      for (int i = 0; i < 5; i++) begin
         f[i]     = re0 + 32'(i);
         f[5 + i] = img0 + 32'(i);
      end
      return f;
   endfunction

   function automatic frame_t dut_frame();
      frame_t f;
      f[0] = a_re;  f[1] = b_re;  f[2] = c_re;  f[3] = d_re;  f[4] = e_re;
      f[5] = a_img; f[6] = b_img; f[7] = c_img; f[8] = d_img; f[9] = e_img;
      return f;
   endfunction

   // Called at posedge+1; returns at posedge+1 just after the sample was accepted.
   task automatic send(input logic [31:0] re, input logic [31:0] img, input logic sof);
      int waited = 0;
      in_valid = 1'b1;
      in_re    = re;
      in_img   = img;
      in_sof   = sof;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
         waited++;
         stalls++;
         @(negedge clk);
      end
      if (!in_ready) check("send_timeout", 1'b0, 1'b1);
      @(posedge clk);
      #1;
      last_acc_cyc = cyc;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic check_reset_state(input string tag);
      @(negedge clk);
      check({tag, "_out_valid"}, out_valid, 1'b0);
      check({tag, "_in_ready"}, in_ready, 1'b1);
      check({tag, "_outputs"}, dut_frame(), '0);
`ifdef RADIX5_GATHER_ERR_EN
      check({tag, "_frame_err"}, frame_err, 1'b0);
`endif
   endtask

   task automatic wait_drained(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check(tag, exp_q.size(), 0);
   endtask

   // Monitor: pops on every transfer and checks that a stalled frame holds.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", dut_frame(), prev_fr);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_frame", 1'b1, 1'b0);
            else                   check("frame", dut_frame(), exp_q.pop_front());
            pop_cyc.push_back(cyc);
            n_pop++;
         end
         prev_stall = out_valid && !out_ready;
         prev_fr    = dut_frame();
      end
   end

   initial begin
      int acc5;
      int pops0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_state("t0_reset");

      // Streaming two frames with out_ready high.
      do_reset();
      out_ready = 1'b1;
      stalls = 0;
      pop_cyc.delete();
      pops0 = n_pop;
      exp_q.push_back(seq_frame(32'd1, 32'd101));
      exp_q.push_back(seq_frame(32'd6, 32'd106));
      for (int i = 1; i <= 5; i++) send(32'(i), 32'(100 + i), i == 1);
      acc5 = last_acc_cyc;
      for (int i = 6; i <= 10; i++) send(32'(i), 32'(100 + i), i == 6);
      idle();
      @(negedge clk);
      check("t1_pops", n_pop - pops0, 2);
      check("t1_in_ready_stream", stalls, 0);
      if (pop_cyc.size() == 2) begin
         check("t1_latency_f1", pop_cyc[0], acc5);
         check("t1_latency_f2", pop_cyc[1], last_acc_cyc);
      end else begin
         check("t1_pop_cycles", pop_cyc.size(), 2);
      end
      @(negedge clk);
      check("t1_valid_pulse", out_valid, 1'b0);
      check("t1_in_ready_end", in_ready, 1'b1);

      // Back-pressure: both banks fill, in_ready drops, one-cycle drain.
      do_reset();
      out_ready = 1'b0;
      exp_q.push_back(seq_frame(32'd1, 32'd101));
      exp_q.push_back(seq_frame(32'd6, 32'd106));
      for (int i = 1; i <= 10; i++) send(32'(i), 32'(100 + i), i == 1 || i == 6);
      in_re  = 32'd11;
      in_img = 32'd111;
      in_sof = 1'b1;
      @(negedge clk);
      check("t2_in_ready_full", in_ready, 1'b0);
      check("t2_out_valid", out_valid, 1'b1);
      check("t2_a_re_held", a_re, 32'd1);
      repeat (3) @(negedge clk);
      check("t2_a_re_still", a_re, 32'd1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("t2_a_re_next", a_re, 32'd6);
      check("t2_in_ready_rise", in_ready, 1'b1);
      @(posedge clk);
      #1;
      send(32'd12, 32'd112, 1'b0);
      idle();
      out_ready = 1'b1;
      wait_drained("t2_drained");

      // Mid-frame sof re-alignment.
      do_reset();
      out_ready = 1'b1;
      exp_q.push_back(seq_frame(32'd50, 32'd150));
      for (int i = 1; i <= 3; i++) send(32'(i), 32'(100 + i), i == 1);
      for (int i = 50; i <= 54; i++) send(32'(i), 32'(100 + i), i == 50);
      idle();
      wait_drained("t3_realign");
`ifdef RADIX5_GATHER_ERR_EN
      check("t3_frame_err", frame_err, 1'b1);
      repeat (5) @(negedge clk);
      check("t3_frame_err_sticky", frame_err, 1'b1);
`endif

      // Reset with a full bank and a partial frame outstanding.
      do_reset();
      out_ready = 1'b0;
      for (int i = 1; i <= 7; i++) send(32'(i), 32'(100 + i), i == 1 || i == 6);
      idle();
      @(negedge clk);
      check("t4_pre_valid", out_valid, 1'b1);
      do_reset();
      check_reset_state("t4_reset");
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      exp_q.push_back(seq_frame(32'd1, 32'd101));
      for (int i = 1; i <= 5; i++) send(32'(i), 32'(100 + i), i == 1);
      idle();
      wait_drained("t4_clean_frame");

      // Random valid gaps and back-pressure over 1000 frames.
      do_reset();
      pops0 = n_pop;
      rand_on = 1'b1;
      fork
         begin
            while (rand_on) begin
               out_ready = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
         end
      join_none
      for (int f = 0; f < 1000; f++) begin
         exp_q.push_back(seq_frame(32'(f << 4), 32'h8000_0000 | 32'(f << 4)));
         for (int i = 0; i < 5; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               idle();
               @(posedge clk);
               #1;
            end
            send(32'((f << 4) | i), 32'h8000_0000 | 32'((f << 4) | i), i == 0);
         end
      end
      idle();
      rand_on = 1'b0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      wait_drained("t5_drained");
      check("t5_frame_count", n_pop - pops0, 1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
